// File: rtl/ts_sync_align_pkg.sv
// Shared constants and state encoding for the TS sync aligner.
package ts_sync_align_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h47;
  localparam int         PKT_LEN_188 = 188;
  localparam int         PKT_LEN_204 = 204;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_e;

endpackage

// File: rtl/ts_sync_align_sync_hyst_fsm.sv
// Hit/miss hysteresis state machine; decides lock state, which bytes are
// forwarded, when a missing sync is tolerated, and when lock is lost.
module sync_hyst_fsm
  import ts_sync_align_pkg::*;
#(
  parameter int P_LOCK_CNT   = 3,
  parameter int P_UNLOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        pos_zero,
  input  logic        is_sync,
  output sync_state_e state,
  output logic        fwd,
  output logic        tol_err,
  output logic        loss
);

  logic [2:0] hit;
  logic [2:0] miss;
  logic       hit_done;
  logic       miss_done;

  assign hit_done  = (hit + 3'd1) == 3'(P_LOCK_CNT);
  assign miss_done = (miss + 3'd1) == 3'(P_UNLOCK_CNT);

  // The unlocking byte is dropped along with the rest of its packet.
  always_comb begin
    fwd     = 1'b0;
    tol_err = 1'b0;
    loss    = 1'b0;
    if (valid) begin
      case (state)
        VERIFY: fwd = pos_zero && is_sync && hit_done;
        LOCK: begin
          if (pos_zero && !is_sync) begin
            loss    = miss_done;
            fwd     = !miss_done;
            tol_err = !miss_done;
          end else begin
            fwd = 1'b1;
          end
        end
        default: fwd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      hit   <= 3'd0;
      miss  <= 3'd0;
    end else if (valid) begin
      case (state)
        HUNT: begin
          if (is_sync) begin
            state <= VERIFY;
            hit   <= 3'd1;
            miss  <= 3'd0;
          end
        end
        VERIFY: begin
          if (pos_zero) begin
            if (!is_sync) begin
              state <= HUNT;
              hit   <= 3'd0;
            end else if (hit_done) begin
              state <= LOCK;
              hit   <= 3'd0;
              miss  <= 3'd0;
            end else begin
              hit <= hit + 3'd1;
            end
          end
        end
        LOCK: begin
          if (pos_zero) begin
            if (is_sync) begin
              miss <= 3'd0;
            end else if (miss_done) begin
              state <= HUNT;
              hit   <= 3'd0;
              miss  <= 3'd0;
            end else begin
              miss <= miss + 3'd1;
            end
          end
        end
        default: begin
          state <= HUNT;
          hit   <= 3'd0;
          miss  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ts_sync_align.sv
// TS packet aligner: hunts 0x47 at packet spacing and forwards only whole,
// aligned packets once lock is confirmed.
module ts_sync_align
  import ts_sync_align_pkg::*;
#(
  parameter int P_PKT_LEN    = 188,
  parameter int P_LOCK_CNT   = 3,
  parameter int P_UNLOCK_CNT = 3,
  parameter int U_DLY        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raw_i_valid,
  input  logic [7:0]  raw_i_data,
  output logic        ts_o_sync,
  output logic        ts_o_valid,
  output logic [7:0]  ts_o_data,
  output logic        ts_o_err,
  output logic        sync_lock,
  output logic [15:0] sync_loss_cnt
);

  localparam logic [7:0] POS_LAST = 8'(P_PKT_LEN - 1);

  if (!(P_PKT_LEN == PKT_LEN_188 || P_PKT_LEN == PKT_LEN_204) ||
      P_LOCK_CNT < 2 || P_LOCK_CNT > 7 ||
      P_UNLOCK_CNT < 1 || P_UNLOCK_CNT > 7 || U_DLY < 0) begin : g_bad_param
    $error("ts_sync_align: illegal parameter value");
  end

  sync_state_e state;
  logic [7:0]  pos;
  logic        pos_zero;
  logic        is_sync;
  logic        fwd;
  logic        tol_err;
  logic        loss;

  assign pos_zero  = (pos == 8'd0);
  assign is_sync   = (raw_i_data == SYNC_BYTE);
  assign sync_lock = (state == LOCK);

  sync_hyst_fsm #(
    .P_LOCK_CNT  (P_LOCK_CNT),
    .P_UNLOCK_CNT(P_UNLOCK_CNT)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (raw_i_valid),
    .pos_zero(pos_zero),
    .is_sync (is_sync),
    .state   (state),
    .fwd     (fwd),
    .tol_err (tol_err),
    .loss    (loss)
  );

  // While hunting, a candidate sync re-anchors the position so the byte
  // after it is position 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 8'd0;
    end else if (raw_i_valid) begin
      if (state == HUNT)
        pos <= is_sync ? 8'd1 : 8'd0;
      else if (pos == POS_LAST)
        pos <= 8'd0;
      else
        pos <= pos + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_o_sync     <= 1'b0;
      ts_o_valid    <= 1'b0;
      ts_o_data     <= 8'h00;
      ts_o_err      <= 1'b0;
      sync_loss_cnt <= 16'd0;
    end else begin
      ts_o_valid <= fwd;
      ts_o_sync  <= fwd && pos_zero;
      ts_o_err   <= tol_err;
      if (fwd)
        ts_o_data <= tol_err ? SYNC_BYTE : raw_i_data;
      if (loss && sync_loss_cnt != 16'hFFFF)
        sync_loss_cnt <= sync_loss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ts_sync_align.sv
// Randomized bench for ts_sync_align against a packet-level reference model.
module tb_ts_sync_align;

  localparam int          LC   = 3;
  localparam int          UC   = 3;
  localparam logic [7:0]  SYNC = 8'h47;

  typedef struct packed {
    logic        v;
    logic        s;
    logic        e;
    logic [7:0]  d;
    logic        lk;
    logic [15:0] loss;
  } out_t;

  typedef struct {
    logic       iv;
    logic [7:0] ib;
    out_t       o;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic raw_valid = 1'b0;
  logic [7:0] raw_data = 8'h00;

  logic a_sync, a_valid, a_err, a_lock;
  logic [7:0] a_data;
  logic [15:0] a_loss;
  logic b_sync, b_valid, b_err, b_lock;
  logic [7:0] b_data;
  logic [15:0] b_loss;

  int total = 0;
  int bad = 0;
  int shown = 0;

  logic [7:0] stim[$];
  cyc_t       cyc[$];
  out_t       exp_q[$];

  always #5 clk = ~clk;

  ts_sync_align #(.P_PKT_LEN(188), .P_LOCK_CNT(LC), .P_UNLOCK_CNT(UC), .U_DLY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .raw_i_valid(raw_valid), .raw_i_data(raw_data),
    .ts_o_sync(a_sync), .ts_o_valid(a_valid), .ts_o_data(a_data), .ts_o_err(a_err),
    .sync_lock(a_lock), .sync_loss_cnt(a_loss));

  ts_sync_align #(.P_PKT_LEN(204), .P_LOCK_CNT(LC), .P_UNLOCK_CNT(UC), .U_DLY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .raw_i_valid(raw_valid), .raw_i_data(raw_data),
    .ts_o_sync(b_sync), .ts_o_valid(b_valid), .ts_o_data(b_data), .ts_o_err(b_err),
    .sync_lock(b_lock), .sync_loss_cnt(b_loss));

  function automatic logic [7:0] rnd_no_sync();
    logic [7:0] x;
    x = 8'($urandom);
    if (x == SYNC) x = 8'h46;
    return x;
  endfunction

  task automatic add_junk(input int n);
    repeat (n) stim.push_back(rnd_no_sync());
  endtask

  task automatic add_pkt(input int len, input logic [7:0] sb);
    stim.push_back(sb);
    repeat (len - 1) stim.push_back(rnd_no_sync());
  endtask

  function automatic out_t sample(input bit b204);
    out_t o;
    if (b204) begin
      o.v = b_valid; o.s = b_sync; o.e = b_err; o.d = b_valid ? b_data : 8'h00;
      o.lk = b_lock; o.loss = b_loss;
    end else begin
      o.v = a_valid; o.s = a_sync; o.e = a_err; o.d = a_valid ? a_data : 8'h00;
      o.lk = a_lock; o.loss = a_loss;
    end
    return o;
  endfunction

  task automatic do_reset();
    raw_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives stim[] with random idle gaps; records per-cycle input and output.
  task automatic run(input bit b204, input int gap_pct);
    cyc_t c;
    cyc.delete();
    foreach (stim[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        raw_valid = 1'b0;
        @(posedge clk); #1;
        c.iv = 1'b0; c.ib = 8'h00; c.o = sample(b204);
        cyc.push_back(c);
      end
      raw_valid = 1'b1;
      raw_data  = stim[i];
      @(posedge clk); #1;
      c.iv = 1'b1; c.ib = stim[i]; c.o = sample(b204);
      cyc.push_back(c);
    end
    raw_valid = 1'b0;
  endtask

  // Reference: sync positions are anchor + n*len counted in accepted bytes.
  task automatic build_expect(input int len);
    int mode, anchor, k, hits, misses, loss;
    bit at0;
    logic [7:0] b;
    out_t o;
    mode = 0; anchor = 0; k = 0; hits = 0; misses = 0; loss = 0;
    exp_q.delete();
    foreach (cyc[i]) begin
      o = '0;
      if (cyc[i].iv) begin
        b   = cyc[i].ib;
        at0 = ((k - anchor) % len) == 0;
        if (mode == 0) begin
          if (b == SYNC) begin mode = 1; anchor = k; hits = 1; end
        end else if (mode == 1) begin
          if (at0) begin
            if (b != SYNC) mode = 0;
            else begin
              hits++;
              if (hits == LC) begin
                mode = 2; misses = 0;
                o.v = 1'b1; o.s = 1'b1; o.d = b;
              end
            end
          end
        end else if (at0 && b != SYNC) begin
          if (misses + 1 < UC) begin
            misses++;
            o.v = 1'b1; o.s = 1'b1; o.e = 1'b1; o.d = SYNC;
          end else begin
            mode = 0;
            if (loss < 65535) loss++;
          end
        end else begin
          o.v = 1'b1; o.s = at0; o.d = b;
          if (at0) misses = 0;
        end
        k++;
      end
      o.lk = (mode == 2);
      o.loss = 16'(loss);
      exp_q.push_back(o);
    end
  endtask

  task automatic test_reset();
    raw_valid = 1'b1;
    repeat (3) begin raw_data = 8'($urandom); @(posedge clk); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({a_sync, a_valid, a_data, a_err, a_lock, a_loss} !== 29'd0) begin
      bad++;
      $display("FAIL reset_a got=%b %b %h %b %b %0d want all zero", a_sync, a_valid, a_data, a_err, a_lock, a_loss);
    end
    total++;
    if ({b_sync, b_valid, b_data, b_err, b_lock, b_loss} !== 29'd0) begin
      bad++;
      $display("FAIL reset_b got=%b %b %h %b %b %0d want all zero", b_sync, b_valid, b_data, b_err, b_lock, b_loss);
    end
    raw_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_lock();
    int nv, ns, ne, first_lk;
    do_reset();
    stim.delete();
    add_junk(37);
    repeat (5) add_pkt(188, SYNC);
    run(1'b0, 0);
    build_expect(188);
    foreach (cyc[i]) begin
      total++;
      if (cyc[i].o !== exp_q[i]) begin
        bad++;
        if (shown++ < 20) $display("FAIL clean_lock cyc %0d got=%p want=%p", i, cyc[i].o, exp_q[i]);
      end
    end
    nv = 0; ns = 0; ne = 0; first_lk = -1;
    foreach (cyc[i]) begin
      nv += int'(cyc[i].o.v); ns += int'(cyc[i].o.s); ne += int'(cyc[i].o.e);
      if (first_lk < 0 && cyc[i].o.lk) first_lk = i;
    end
    total++; if (nv !== 564) begin bad++; $display("FAIL clean_valid_count got=%0d want=564", nv); end
    total++; if (ns !== 3) begin bad++; $display("FAIL clean_sync_count got=%0d want=3", ns); end
    total++; if (ne !== 0) begin bad++; $display("FAIL clean_err_count got=%0d want=0", ne); end
    total++; if (first_lk !== 413) begin bad++; $display("FAIL clean_lock_cycle got=%0d want=413", first_lk); end
  endtask

  task automatic test_false_sync();
    int nv, first_v;
    do_reset();
    stim.delete();
    add_junk(10);
    stim.push_back(SYNC);
    add_junk(39);
    repeat (5) add_pkt(188, SYNC);
    run(1'b0, 0);
    build_expect(188);
    foreach (cyc[i]) begin
      total++;
      if (cyc[i].o !== exp_q[i]) begin
        bad++;
        if (shown++ < 20) $display("FAIL false_sync cyc %0d got=%p want=%p", i, cyc[i].o, exp_q[i]);
      end
    end
    nv = 0; first_v = -1;
    foreach (cyc[i]) begin
      nv += int'(cyc[i].o.v);
      if (first_v < 0 && cyc[i].o.v) first_v = i;
    end
    // The false candidate occupies the real sync at 50, so lock lands on 238/426/614.
    total++; if (first_v !== 614) begin bad++; $display("FAIL false_first_valid got=%0d want=614", first_v); end
    total++; if (nv !== 376) begin bad++; $display("FAIL false_valid_count got=%0d want=376", nv); end
  endtask

  task automatic test_tolerated_miss();
    do_reset();
    stim.delete();
    for (int p = 0; p < 8; p++) add_pkt(188, (p == 5) ? 8'h00 : SYNC);
    run(1'b0, 0);
    build_expect(188);
    foreach (cyc[i]) begin
      total++;
      if (cyc[i].o !== exp_q[i]) begin
        bad++;
        if (shown++ < 20) $display("FAIL tol_miss cyc %0d got=%p want=%p", i, cyc[i].o, exp_q[i]);
      end
    end
    total++;
    if ({cyc[940].o.v, cyc[940].o.s, cyc[940].o.e, cyc[940].o.d, cyc[940].o.lk} !== {3'b111, SYNC, 1'b1}) begin
      bad++; $display("FAIL tol_pkt6_head got=%p want v=s=e=lk=1 d=47", cyc[940].o);
    end
    total++;
    if ({cyc[1128].o.s, cyc[1128].o.e, cyc[1128].o.lk} !== 3'b101) begin
      bad++; $display("FAIL tol_pkt7_head got=%p want s=1 e=0 lk=1", cyc[1128].o);
    end
  endtask

  task automatic test_unlock();
    int nv3;
    do_reset();
    stim.delete();
    for (int p = 0; p < 8; p++) add_pkt(188, (p >= 3 && p <= 5) ? rnd_no_sync() : SYNC);
    run(1'b0, 0);
    build_expect(188);
    foreach (cyc[i]) begin
      total++;
      if (cyc[i].o !== exp_q[i]) begin
        bad++;
        if (shown++ < 20) $display("FAIL unlock cyc %0d got=%p want=%p", i, cyc[i].o, exp_q[i]);
      end
    end
    nv3 = 0;
    for (int i = 940; i < 1128; i++) nv3 += int'(cyc[i].o.v);
    total++; if ({cyc[564].o.s, cyc[564].o.e} !== 2'b11) begin bad++; $display("FAIL unlock_bad1 got=%p want s=e=1", cyc[564].o); end
    total++; if ({cyc[752].o.s, cyc[752].o.e} !== 2'b11) begin bad++; $display("FAIL unlock_bad2 got=%p want s=e=1", cyc[752].o); end
    total++; if (nv3 !== 0) begin bad++; $display("FAIL unlock_pkt_valid got=%0d want=0", nv3); end
    total++; if (cyc[940].o.lk !== 1'b0) begin bad++; $display("FAIL unlock_lock got=%b want=0", cyc[940].o.lk); end
    total++; if (cyc[cyc.size()-1].o.loss !== 16'd1) begin bad++; $display("FAIL unlock_loss_cnt got=%0d want=1", cyc[cyc.size()-1].o.loss); end
  endtask

  task automatic test_gapped();
    logic [7:0] got_d[$];
    int k, lk_byte, ns;
    do_reset();
    stim.delete();
    add_junk(13);
    repeat (6) add_pkt(204, SYNC);
    run(1'b1, 50);
    build_expect(204);
    foreach (cyc[i]) begin
      total++;
      if (cyc[i].o !== exp_q[i]) begin
        bad++;
        if (shown++ < 20) $display("FAIL gapped cyc %0d got=%p want=%p", i, cyc[i].o, exp_q[i]);
      end
    end
    k = 0; lk_byte = -1; ns = 0;
    foreach (cyc[i]) begin
      if (cyc[i].o.v) got_d.push_back(cyc[i].o.d);
      ns += int'(cyc[i].o.s);
      if (lk_byte < 0 && cyc[i].o.lk) lk_byte = cyc[i].iv ? k : -2;
      if (cyc[i].iv) k++;
    end
    total++; if (lk_byte !== 421) begin bad++; $display("FAIL gapped_lock_byte got=%0d want=421", lk_byte); end
    total++; if (ns !== 4) begin bad++; $display("FAIL gapped_sync_count got=%0d want=4", ns); end
    total++;
    if (got_d.size() !== 816) begin
      bad++; $display("FAIL gapped_byte_count got=%0d want=816", got_d.size());
    end else begin
      for (int j = 0; j < 816; j++) begin
        total++;
        if (got_d[j] !== stim[421 + j]) begin
          bad++;
          if (shown++ < 20) $display("FAIL gapped_order idx %0d got=%h want=%h", j, got_d[j], stim[421 + j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int first_lk;
    do_reset();
    stim.delete();
    repeat (3) add_pkt(188, SYNC);
    stim.push_back(SYNC);
    add_junk(99);
    run(1'b0, 0);
    total++;
    if ({a_valid, a_lock} !== 2'b11) begin bad++; $display("FAIL rstmid_pre got v=%b lk=%b want 1 1", a_valid, a_lock); end
    raw_valid = 1'b1;
    raw_data = rnd_no_sync();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({a_sync, a_valid, a_data, a_err, a_lock, a_loss} !== 29'd0) begin
      bad++;
      $display("FAIL rstmid_clear got=%b %b %h %b %b %0d want all zero", a_sync, a_valid, a_data, a_err, a_lock, a_loss);
    end
    raw_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stim.delete();
    add_junk(87);
    repeat (4) add_pkt(188, SYNC);
    run(1'b0, 0);
    build_expect(188);
    foreach (cyc[i]) begin
      total++;
      if (cyc[i].o !== exp_q[i]) begin
        bad++;
        if (shown++ < 20) $display("FAIL rstmid cyc %0d got=%p want=%p", i, cyc[i].o, exp_q[i]);
      end
    end
    first_lk = -1;
    foreach (cyc[i]) if (first_lk < 0 && cyc[i].o.lk) first_lk = i;
    total++; if (first_lk !== 463) begin bad++; $display("FAIL rstmid_relock got=%0d want=463", first_lk); end
  endtask

  task automatic test_random();
    logic [7:0] sb;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      stim.delete();
      repeat ($urandom_range(50)) stim.push_back(8'($urandom));
      repeat (12) begin
        sb = ($urandom_range(99) < 30) ? 8'($urandom) : SYNC;
        stim.push_back(sb);
        repeat (187) stim.push_back(($urandom_range(99) < 3) ? SYNC : 8'($urandom));
      end
      run(1'b0, 25);
      build_expect(188);
      foreach (cyc[i]) begin
        total++;
        if (cyc[i].o !== exp_q[i]) begin
          bad++;
          if (shown++ < 20) $display("FAIL random%0d cyc %0d got=%p want=%p", r, i, cyc[i].o, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_false_sync();
    test_tolerated_miss();
    test_unlock();
    test_gapped();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ts_sync_align.md
# ts_sync_align

Upstream packet aligner for the scrambler channel. Takes the raw, unframed TS byte stream and hunts for the 0x47 sync byte at 188-byte spacing. Confirms lock with a hit/miss hysteresis state machine. Forwards only whole, aligned packets as the `ts_i_sync` / `ts_i_valid` / `ts_i_data` stream the scrambler configuration stage consumes, with lock status and a sync-loss counter for the local-bus status registers.

## Interface
Parameters:
- `P_PKT_LEN`, 188: packet length in bytes; legal values are 188 and 204.
- `P_LOCK_CNT`, 3: consecutive correct sync bytes needed to declare lock; range 2..7.
- `P_UNLOCK_CNT`, 3: consecutive missing sync bytes that drop lock; range 1..7.
- `U_DLY`, 1: simulation register delay.

Ports:
- `clk`, in, 1: single clock; all logic is in this domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `raw_i_valid`, in, 1: a raw byte is present this cycle; gaps are allowed.
- `raw_i_data`, in, 8: raw TS byte.
- `ts_o_sync`, out, 1: first byte of a forwarded packet.
- `ts_o_valid`, out, 1: forwarded byte valid.
- `ts_o_data`, out, 8: forwarded byte.
- `ts_o_err`, out, 1: high together with `ts_o_sync` when that packet's sync byte was missing and tolerated.
- `sync_lock`, out, 1: high while the state is LOCK.
- `sync_loss_cnt`, out, 16: number of LOCK→HUNT transitions; saturates at 0xFFFF.

## Operation
- A byte position counter `pos` (8 bits, 0..`P_PKT_LEN`-1) advances only on `raw_i_valid`. It wraps from `P_PKT_LEN`-1 to 0.
- Bytes with `raw_i_valid`=0 are ignored entirely; no state changes on idle cycles.
- HUNT state:
  - A byte equal to 0x47 → VERIFY with `pos`=1 and `hit`=1.
  - Any other byte stays in HUNT.
  - Nothing is forwarded.
- VERIFY state:
  - At `pos`=0 with byte 0x47: `hit`+1.
  - If `hit` reaches `P_LOCK_CNT` → LOCK, and this byte is forwarded as the first `ts_o_sync`.
  - At `pos`=0 with any other byte → HUNT, and that same byte is not re-examined.
  - No other bytes are forwarded.
- LOCK state: every valid byte is forwarded. At `pos`=0:
  - Byte 0x47: forward it, clear `miss`.
  - Other byte with `miss`+1 < `P_UNLOCK_CNT`: `miss`+1. Forward the packet with `ts_o_sync`=1, `ts_o_err`=1, and `ts_o_data` forced to 0x47.
  - Other byte with `miss`+1 = `P_UNLOCK_CNT`: → HUNT and `sync_loss_cnt`+1 (saturating). That byte and the rest of its packet are not forwarded, so partial packets are never emitted.
- `hit` and `miss` are 3-bit counters, cleared on every state change.

## Timing
- Output registers give a fixed latency of 1 cycle from `raw_i_*` to `ts_o_*`. Valid gaps pass through unchanged; there is no buffering and no backpressure.
- `sync_lock` rises in the cycle after the lock-confirming byte is accepted, the same cycle its `ts_o_sync` appears. It falls in the cycle after the unlocking byte is accepted.
- Reset values: `ts_o_sync`=0, `ts_o_valid`=0, `ts_o_data`=0x00, `ts_o_err`=0, `sync_lock`=0, `sync_loss_cnt`=0. Internally, state=HUNT and `pos`/`hit`/`miss`=0.
- Reset asserted mid-packet: outputs clear immediately (asynchronously). After release, alignment restarts from HUNT and needs `P_LOCK_CNT` syncs again.
- `ts_o_err` is only ever high in a cycle where `ts_o_sync`=1 and `ts_o_valid`=1.

## Structure
- Shared package/header holds:
  - the sync byte constant 0x47;
  - the state encodings HUNT=2'd0, VERIFY=2'd1, LOCK=2'd2;
  - the packet-length constants 188 and 204.
- One natural sub-module, `sync_hyst_fsm`, holds the state register, `hit`/`miss` counters and transition logic. It is driven by `raw_i_valid`, a `pos==0` flag and a "byte is 0x47" flag. It outputs the state, a forward enable and a loss pulse.
- The top level owns `pos`, the output registers and `sync_loss_cnt`.

## Test plan
- **Clean lock:** 5 aligned 188-byte packets preceded by 37 junk bytes, no gaps, defaults. Required:
  - `sync_lock` rises at the 3rd sync byte;
  - packets 3–5 are forwarded intact (3×188 `ts_o_valid` cycles), each with one `ts_o_sync`;
  - `ts_o_err`=0 throughout.
- **False sync:** a 0x47 inside junk at offset 10, real sync at offset 50, no 0x47 at offset 198. Required: HUNT→VERIFY→HUNT, then lock on the real alignment; no bytes are forwarded before lock.
- **Tolerated miss:** while locked, packet 6 sync = 0x00. Required: packet 6 is forwarded with first byte 0x47, `ts_o_sync`=1 and `ts_o_err`=1; `sync_lock` stays 1; packet 7 (correct sync) has `ts_o_err`=0.
- **Unlock:** 3 consecutive corrupted syncs while locked. Required: packets with the 1st and 2nd bad syncs are forwarded with `ts_o_err`=1; the 3rd packet has zero `ts_o_valid` cycles; `sync_lock`=0; `sync_loss_cnt`=1.
- **Gapped input:** `raw_i_valid` randomly low 50% of cycles, with `P_PKT_LEN`=204. Required: lock is still reached after 3 syncs, and output byte order and count exactly match input.
- **Reset mid-packet:** assert `rst_n`=0 at locked byte 100. Required: all outputs are 0 in the same cycle; after release, `sync_lock` stays 0 until 3 further syncs are seen.
